// File: rtl/ultrasonic_ranger_mc.sv
// Multi-channel round-robin ultrasonic ranger: trigger, echo timing in us, cm conversion, tagged results.
// Optional per-channel smoothing filter on reported distance when ULTRASONIC_AVG_EN is defined.
module ultrasonic_ranger_mc #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int NUM_CH          = 4,
  parameter int TRIG_US         = 10,
  parameter int RISE_TIMEOUT_US = 500,
  parameter int ECHO_MAX_US     = 25000,
  parameter int HOLDOFF_US      = 10000,
  parameter int DIST_W          = 10,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auto_en,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] echo,
  output logic [DIST_W-1:0] dist_cm,
  output logic [CH_W-1:0]   dist_ch,
  output logic              dist_valid,
  output logic              timeout,
  output logic              busy,
  output logic [2:0]        state_out
);

  localparam int US_DIV   = CLK_HZ / 1_000_000;
  localparam int PRE_W    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int CNT_MAX  = (TRIG_US > RISE_TIMEOUT_US ? TRIG_US : RISE_TIMEOUT_US) >
                            (ECHO_MAX_US > HOLDOFF_US ? ECHO_MAX_US : HOLDOFF_US) ?
                            (TRIG_US > RISE_TIMEOUT_US ? TRIG_US : RISE_TIMEOUT_US) :
                            (ECHO_MAX_US > HOLDOFF_US ? ECHO_MAX_US : HOLDOFF_US);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int PROD_W   = $clog2(ECHO_MAX_US * 1130 + 1);
  localparam int DIST_MAX = (1 << DIST_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4,
    S_SELECT    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic                started_q, started_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0]    us_cnt_q, us_cnt_d;
  logic [NUM_CH-1:0]   sync1_q, sync2_q;
  logic [DIST_W-1:0]   dist_cm_q;
  logic [CH_W-1:0]     dist_ch_q;
  logic                dist_valid_q, timeout_q;

  logic                tick, echo_s, post, post_to, found;
  logic [CH_W-1:0]     next_ch;
  int                  start_idx, idx;
  logic [CNT_W-1:0]    meas_us;
  logic [PROD_W-1:0]   prod, scaled;
  logic [DIST_W-1:0]   raw_cm, sample_cm;

  // Two-flop synchroniser per channel; only cur_ch's output is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values, giving a true 2-stage chain.
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

  assign echo_s = sync2_q[cur_ch_q];
  assign tick   = (presc_q == PRE_W'(US_DIV - 1));

  // Round-robin search upward from the channel after the last one serviced.
  always_comb begin
    next_ch   = '0;
    found     = 1'b0;
    idx       = 0;
    start_idx = started_q ? int'(cur_ch_q) + 1 : 0;
    if (start_idx >= NUM_CH) start_idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = start_idx + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ch_en[CH_W'(idx)]) begin
        found   = 1'b1;
        next_ch = CH_W'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    started_d = started_q;
    post      = 1'b0;
    post_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (auto_en && (ch_en != '0)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (found) begin
          cur_ch_d  = next_ch;
          started_d = 1'b1;
          state_d   = S_TRIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        if (tick && (us_cnt_q == CNT_W'(TRIG_US - 1))) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (echo_s) begin
          state_d = S_MEASURE;
        end else if (us_cnt_q == CNT_W'(RISE_TIMEOUT_US)) begin
          post    = 1'b1;
          post_to = 1'b1;
          state_d = S_HOLDOFF;
        end
      end
      S_MEASURE: begin
        if (us_cnt_q == CNT_W'(ECHO_MAX_US)) begin
          post    = 1'b1;
          post_to = 1'b1;
          state_d = S_HOLDOFF;
        end else if (!echo_s) begin
          post    = 1'b1;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (tick && (us_cnt_q == CNT_W'(HOLDOFF_US - 1)))
          state_d = (auto_en && (ch_en != '0)) ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timebase restarts on every state change so each state lasts whole microseconds.
  always_comb begin
    presc_d  = presc_q + PRE_W'(1);
    us_cnt_d = us_cnt_q;
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      presc_d  = '0;
      us_cnt_d = '0;
    end else if (tick) begin
      presc_d  = '0;
      us_cnt_d = us_cnt_q + CNT_W'(1);
    end
  end

  // The cycle spent detecting the rise in WAIT_RISE is recovered by counting this cycle's tick.
  assign meas_us = us_cnt_q + CNT_W'(tick);
  assign prod    = PROD_W'(meas_us) * PROD_W'(1130);
  assign scaled  = prod >> 16;
  assign raw_cm  = (32'(scaled) > 32'(DIST_MAX)) ? '1 : DIST_W'(scaled);

`ifdef ULTRASONIC_AVG_EN
  logic [DIST_W-1:0]       filt_q [NUM_CH];
  logic [NUM_CH-1:0]       filt_vld_q;
  logic signed [DIST_W:0]  f_old_s, diff_s, upd_s;

  always_comb begin
    f_old_s   = $signed({1'b0, filt_q[cur_ch_q]});
    diff_s    = $signed({1'b0, raw_cm}) - f_old_s;
    upd_s     = f_old_s + (diff_s >>> 2);
    sample_cm = filt_vld_q[cur_ch_q] ? upd_s[DIST_W-1:0] : raw_cm;
  end

  always_ff @(posedge clk) begin
    if (rst)                   filt_vld_q <= '0;
    else if (post && !post_to) filt_vld_q[cur_ch_q] <= 1'b1;
  end

  // NOTE: filt_q is a storage array without reset; filt_vld_q guards every read until a real sample is loaded.
  always_ff @(posedge clk) begin
    if (post && !post_to) filt_q[cur_ch_q] <= sample_cm;
  end
`else
  assign sample_cm = raw_cm;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_ch_q     <= '0;
      started_q    <= 1'b0;
      presc_q      <= '0;
      us_cnt_q     <= '0;
      dist_cm_q    <= '0;
      dist_ch_q    <= '0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      started_q    <= started_d;
      presc_q      <= presc_d;
      us_cnt_q     <= us_cnt_d;
      dist_valid_q <= post;
      if (post) begin
        dist_cm_q <= post_to ? '1 : sample_cm;
        dist_ch_q <= cur_ch_q;
        timeout_q <= post_to;
      end
    end
  end

  always_comb begin
    trig = '0;
    if (state_q == S_TRIG) trig[cur_ch_q] = 1'b1;
  end

  assign dist_cm    = dist_cm_q;
  assign dist_ch    = dist_ch_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != S_IDLE);
  assign state_out  = state_q;

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Scoreboard bench for ultrasonic_ranger_mc at 1 MHz (one clock per microsecond), shortened holdoff.
module tb_ultrasonic_ranger_mc;
  localparam int HOLD = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       auto_en = 1'b0;
  logic [3:0] ch_en = 4'b0000;
  logic [3:0] trig;
  wire  [3:0] echo_w;
  wire  [3:0] resp_busy;
  logic [9:0] dist_cm;
  logic [1:0] dist_ch;
  logic       dist_valid, timeout, busy;
  logic [2:0] state_out;

  ultrasonic_ranger_mc #(
    .CLK_HZ(1_000_000), .NUM_CH(4), .TRIG_US(10), .RISE_TIMEOUT_US(500),
    .ECHO_MAX_US(25000), .HOLDOFF_US(HOLD), .DIST_W(10)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .ch_en(ch_en), .trig(trig), .echo(echo_w),
    .dist_cm(dist_cm), .dist_ch(dist_ch), .dist_valid(dist_valid), .timeout(timeout),
    .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] cm;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         trig_pulses = 0;
  int         trig_w = 0;
  logic [3:0] trig_prev = 4'b0;
  logic       valid_prev = 1'b0;
  logic [3:0] trig_allowed = 4'b0;
  int         rise_log[$], fall_log[$], valid_log[$];
  int         cfg_d[4] = '{0, 0, 0, 0};
  int         cfg_w[4] = '{0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input int cm, input int to);
    exp_t e;
    e.ch = 2'(ch);
    e.cm = 10'(cm);
    e.to = 1'(to);
    sb.push_back(e);
  endtask

  // Echo responders: after each trig pulse on their channel, wait cfg_d then hold echo for cfg_w cycles.
  for (genvar g = 0; g < 4; g++) begin : g_resp
    logic e_r = 1'b0;
    logic b_r = 1'b0;
    assign echo_w[g]    = e_r;
    assign resp_busy[g] = b_r;
    initial begin
      forever begin
        @(posedge clk); #1;
        if (trig[g]) begin
          while (trig[g]) begin @(posedge clk); #1; end
          if (cfg_w[g] > 0) begin
            b_r = 1'b1;
            repeat (cfg_d[g]) @(posedge clk);
            #1 e_r = 1'b1;
            repeat (cfg_w[g]) @(posedge clk);
            #1 e_r = 1'b0;
            b_r = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each post and polices the trigger pulses.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      trig_prev  = 4'b0;
      trig_w     = 0;
      valid_prev = 1'b0;
    end else begin
      if (dist_valid) begin
        check("valid_single_cycle", valid_prev, 0);
        valid_log.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_post: ch=%0d cm=%0d to=%0b with empty queue", dist_ch, dist_cm, timeout);
        end else begin
          e = sb.pop_front();
          check("post_ch", dist_ch, e.ch);
          check("post_cm", dist_cm, e.cm);
          check("post_timeout", timeout, e.to);
        end
      end
      valid_prev = dist_valid;
      if ((trig != 4'b0) && (trig_prev == 4'b0)) begin
        check("trig_onehot", $countones(trig), 1);
        check("trig_mask", trig & ~trig_allowed, 0);
        check("trig_state", state_out, 1);
        rise_log.push_back(cyc);
        trig_w = 0;
      end
      if (trig != 4'b0) trig_w++;
      if ((trig == 4'b0) && (trig_prev != 4'b0)) begin
        check("trig_width", trig_w, 10);
        trig_pulses++;
        fall_log.push_back(cyc);
      end
      trig_prev = trig;
    end
  end

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while ((trig_pulses < n) && (k < budget)) begin @(posedge clk); #1; k++; end
    check(name, trig_pulses, n);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k = 0;
    while ((state_out != s) && (k < budget)) begin @(posedge clk); #1; k++; end
    check(name, state_out, s);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k = 0;
    while (((sb.size() != 0) || busy) && (k < budget)) begin @(posedge clk); #1; k++; end
    check({tag, "_queue"}, sb.size(), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, state_out, 0);
  endtask

  task automatic wait_echo_idle(input int budget);
    int k = 0;
    while ((resp_busy != 4'b0) && (k < budget)) begin @(posedge clk); #1; k++; end
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst = 1'b1;
    auto_en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_trig"}, trig, 0);
    check({tag, "_state"}, state_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, dist_valid, 0);
    check({tag, "_cm"}, dist_cm, 0);
    check({tag, "_ch"}, dist_ch, 0);
    check({tag, "_timeout"}, timeout, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base, v0, f0, r0, k;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", trig, 0);
    check("rst_state", state_out, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", dist_valid, 0);
    check("rst_cm", dist_cm, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single channel, 580 us echo -> 10 cm
    cfg_d[0] = 100; cfg_w[0] = 580;
    trig_allowed = 4'b0001; ch_en = 4'b0001;
    push(0, 10, 0);
    base = trig_pulses;
    auto_en = 1'b1;
    wait_pulses(base + 1, 100, "p1_trig");
    auto_en = 1'b0;
    wait_drain(3000, "p1");

    // Channels 1 and 3 alternate: 1160 us -> 20 cm, 290 us -> 5 cm
    cfg_d[1] = 40; cfg_w[1] = 1160;
    cfg_d[3] = 60; cfg_w[3] = 290;
    trig_allowed = 4'b1010; ch_en = 4'b1010;
    push(1, 20, 0); push(3, 5, 0); push(1, 20, 0); push(3, 5, 0);
    base = trig_pulses;
    auto_en = 1'b1;
    wait_pulses(base + 4, 20000, "p2_trig");
    auto_en = 1'b0;
    wait_drain(4000, "p2");

    // No echo: rise timeout, then next trigger after holdoff
    cfg_w[0] = 0;
    trig_allowed = 4'b0001; ch_en = 4'b0001;
    v0 = valid_log.size(); f0 = fall_log.size(); r0 = rise_log.size();
    push(0, 1023, 1); push(0, 1023, 1);
    base = trig_pulses;
    auto_en = 1'b1;
    wait_pulses(base + 2, 5000, "p3_trig");
    auto_en = 1'b0;
    wait_drain(3000, "p3");
    check("p3_posts", valid_log.size() - v0, 2);
    if ((valid_log.size() > v0) && (fall_log.size() > f0) && (rise_log.size() > r0 + 1)) begin
      check("rise_timeout_latency", valid_log[v0] - fall_log[f0], 501);
      check("holdoff_gap", rise_log[r0 + 1] - valid_log[v0], HOLD + 1);
    end

    // Reset while triggering
    auto_en = 1'b1;
    wait_state(3'd1, 2000, "p4_in_trig");
    reset_check("rst_in_trig");

    // Reset during the second measurement
    cfg_d[0] = 20; cfg_w[0] = 580;
    push(0, 10, 0);
    base = trig_pulses;
    auto_en = 1'b1;
    wait_pulses(base + 2, 4000, "p5_trig");
    wait_state(3'd3, 200, "p5_in_measure");
    check("p5_before_rst_cm", dist_cm, 10);
    reset_check("rst_in_measure");
    wait_echo_idle(2000);
    check("p5_queue", sb.size(), 0);

    // Filter (20 then 40 cm on ch0)
    cfg_d[0] = 30; cfg_w[0] = 1160;
    push(0, 20, 0);
`ifdef ULTRASONIC_AVG_EN
    push(0, 25, 0);
`else
    push(0, 40, 0);
`endif
    base = trig_pulses;
    auto_en = 1'b1;
    wait_pulses(base + 1, 100, "p6_trig1");
    k = 0;
    while ((sb.size() > 1) && (k < 3000)) begin @(posedge clk); #1; k++; end
    cfg_w[0] = 2320;
    wait_pulses(base + 2, 3000, "p6_trig2");
    auto_en = 1'b0;
    wait_drain(4000, "p6");

    // Echo stuck high: abandon at 25000 us without waiting for the fall; auto_en cleared mid-measure
    cfg_d[0] = 50; cfg_w[0] = 30000;
    push(0, 1023, 1);
    auto_en = 1'b1;
    wait_state(3'd3, 500, "p7_in_measure");
    auto_en = 1'b0;
    wait_drain(27000, "p7");
    check("p7_echo_still_high", echo_w[0], 1);
    wait_echo_idle(6000);

    check("final_queue", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
